// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types and defaults for the burst memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // Default words per cache line (= beats per memory transaction).
    localparam int DEFAULT_BURST_WIDTH = 8;

    // Arbiter transaction state; explicit encodings keep reset/debug values fixed.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    // Requester identity; bit position matches the request vector index.
    typedef enum logic {
        REQ_IC = 1'b0,
        REQ_DC = 1'b1
    } req_id_t;

endpackage
`default_nettype wire

// File: rtl/mem_burst_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter_2
// Purpose  : Combinational two-way round-robin pick between I-cache and
//            D-cache. On a tie the requester that did not win last time wins.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter_2
    import mem_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  req_id_t    i_last_gnt,
    output req_id_t    o_gnt_id,
    output logic       o_gnt_valid
);

    // Pick a winner; o_gnt_id is only meaningful while o_gnt_valid is high.
    always_comb begin
        o_gnt_valid = |i_req;
        o_gnt_id    = REQ_IC;
        if (i_req == 2'b11) begin
            if (i_last_gnt == REQ_IC) begin
                o_gnt_id = REQ_DC;
            end else begin
                o_gnt_id = REQ_IC;
            end
        end else if (i_req[1]) begin
            o_gnt_id = REQ_DC;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_burst_arbiter
// Purpose  : Shares one burst main memory between the I-cache (line fills)
//            and the D-cache (line fills and write-backs). Holds RE/WE for
//            the whole burst, walks the word offset on each memory beat,
//            steers read beats and pulses a per-requester DONE.
// Revision : 1.0 - initial release
// ============================================================================
module mem_burst_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int BURST_WIDTH = DEFAULT_BURST_WIDTH,
    localparam int OFF_W       = $clog2(BURST_WIDTH),
    localparam int LINE_W      = 30 - OFF_W
) (
    input  logic              MEM_CLK,
    input  logic              RST_N,
    input  logic              IC_REQ,
    input  logic [LINE_W-1:0] IC_LINE_ADDR,
    output logic              IC_RVALID,
    output logic              IC_DONE,
    input  logic              DC_REQ,
    input  logic              DC_WE,
    input  logic [LINE_W-1:0] DC_LINE_ADDR,
    input  logic [31:0]       DC_WDATA,
    output logic              DC_RVALID,
    output logic              DC_DONE,
    output logic [31:0]       RDATA,
    output logic [OFF_W-1:0]  WORD_IDX,
    output logic              MEM_RE,
    output logic              MEM_WE,
    output logic [29:0]       MEM_ADDR,
    output logic [31:0]       MEM_DATA_IN,
    input  logic [31:0]       MEM_DOUT,
    input  logic              MEM_VALID
);

    localparam logic [OFF_W-1:0] c_last_idx = OFF_W'(BURST_WIDTH - 1);

    arb_state_t        r_state;
    req_id_t           r_gnt_id;
    req_id_t           r_last_gnt;
    logic [LINE_W-1:0] r_gnt_line;
    logic              r_gnt_we;
    logic [OFF_W-1:0]  r_word_idx;
    logic              r_mem_re;
    logic              r_mem_we;
    logic              r_ic_done;
    logic              r_dc_done;

    logic [1:0]        w_req;
    req_id_t           w_arb_id;
    logic              w_arb_valid;
    logic              w_grant;
    logic              w_grant_we;
    logic [LINE_W-1:0] w_grant_line;
    logic              w_beat;
    logic              w_last_beat;

    assign w_req = {DC_REQ, IC_REQ};

    rr_arbiter_2 u_rr (
        .i_req       (w_req),
        .i_last_gnt  (r_last_gnt),
        .o_gnt_id    (w_arb_id),
        .o_gnt_valid (w_arb_valid)
    );

    // A grant waits for MEM_VALID low so leftover beats from an abandoned or
    // over-long burst are never mistaken for the new transaction's data.
    assign w_grant      = (r_state == IDLE) && w_arb_valid && !MEM_VALID;
    assign w_grant_we   = (w_arb_id == REQ_DC) && DC_WE;
    assign w_grant_line = (w_arb_id == REQ_DC) ? DC_LINE_ADDR : IC_LINE_ADDR;
    assign w_beat       = (r_state == BUSY) && MEM_VALID;
    assign w_last_beat  = w_beat && (r_word_idx == c_last_idx);

    // Transaction FSM with grant latches, beat counter and registered strobes.
    always_ff @(posedge MEM_CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= IDLE;
            r_gnt_id   <= REQ_IC;
            r_last_gnt <= REQ_IC;
            r_gnt_line <= '0;
            r_gnt_we   <= 1'b0;
            r_word_idx <= '0;
            r_mem_re   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_ic_done  <= 1'b0;
            r_dc_done  <= 1'b0;
        end else begin
            r_ic_done <= 1'b0;
            r_dc_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_state    <= BUSY;
                        r_gnt_id   <= w_arb_id;
                        r_last_gnt <= w_arb_id;
                        r_gnt_line <= w_grant_line;
                        r_gnt_we   <= w_grant_we;
                        r_word_idx <= '0;
                        r_mem_re   <= !w_grant_we;
                        r_mem_we   <= w_grant_we;
                    end
                end
                BUSY: begin
                    if (w_beat) begin
                        r_word_idx <= r_word_idx + OFF_W'(1);
                    end
                    if (w_last_beat) begin
                        r_state   <= DONE;
                        r_mem_re  <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_ic_done <= (r_gnt_id == REQ_IC);
                        r_dc_done <= (r_gnt_id == REQ_DC);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign MEM_RE    = r_mem_re;
    assign MEM_WE    = r_mem_we;
    assign MEM_ADDR  = {r_gnt_line, r_word_idx};
    assign WORD_IDX  = r_word_idx;
    assign IC_DONE   = r_ic_done;
    assign DC_DONE   = r_dc_done;
    assign RDATA     = MEM_DOUT;

    // Read beats go only to the granted cache and only for a fill.
    assign IC_RVALID = w_beat && !r_gnt_we && (r_gnt_id == REQ_IC);
    assign DC_RVALID = w_beat && !r_gnt_we && (r_gnt_id == REQ_DC);

    // Write data is passed straight through so the D-cache can answer the
    // presented WORD_IDX within the same beat.
    assign MEM_DATA_IN = ((r_state == BUSY) && r_gnt_we && (r_gnt_id == REQ_DC))
                         ? DC_WDATA : 32'd0;

endmodule
`default_nettype wire
